l2_request_mux: RTL

- Per-core request staging and selection stage ahead of the shared L2 request bus.
- Holds one pending request per requester in a slot register and drives the slot-valid vector to the round-robin arbiter.
- Consumes the arbiter's registered one-hot grant and muxes the granted slot onto a single valid/ready output channel.
- Sits between the per-core store/miss queues (upstream) and the L2 interface (downstream).

---
 rtl/l2_request_mux.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/l2_request_mux.sv
// l2_request_mux: per-core request slots feeding the shared L2 request bus.
// Each requester owns one slot. The slot-valid vector goes to an external
// round-robin arbiter, and the registered one-hot grant that comes back selects
// which slot is moved into the output register for the valid/ready channel.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | output empty; present slot_valid to arbiter, wait for any slot
// WAIT_GRANT  | arbiter grant now reflects last cycle's request; take one slot
// ISSUE       | output request valid and held until out_ready; request masked
module l2_request_mux #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2,
  localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             in_valid,
  output logic [NUM_PORTS-1:0]             in_ready,
  input  logic [NUM_PORTS*OP_WIDTH-1:0]    in_op,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  in_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  output logic [NUM_PORTS-1:0]             arb_request,
  input  logic [NUM_PORTS-1:0]             arb_grant_oh,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OP_WIDTH-1:0]              out_op,
  output logic [ADDR_WIDTH-1:0]            out_addr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [PORT_W-1:0]                out_port
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_ISSUE      = 2'd2
  } state_t;

  localparam logic [NUM_PORTS-1:0] P_ONE = NUM_PORTS'(1);

  state_t                  r_state;
  logic [NUM_PORTS-1:0]    r_slot_valid;
  logic [OP_WIDTH-1:0]     r_slot_op   [NUM_PORTS];
  logic [ADDR_WIDTH-1:0]   r_slot_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   r_slot_data [NUM_PORTS];

  logic                    r_out_valid;
  logic [OP_WIDTH-1:0]     r_out_op;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [PORT_W-1:0]       r_out_port;

  logic [NUM_PORTS-1:0]    w_accept;
  logic [NUM_PORTS-1:0]    w_grant;
  logic                    w_grant_ok;
  logic [PORT_W-1:0]       w_grant_idx;
  logic [NUM_PORTS-1:0]    w_clear;

  // A grant only counts against occupied slots; stale or multi-hot grants are ignored.
  assign w_accept   = in_valid & ~r_slot_valid;
  assign w_grant    = arb_grant_oh & r_slot_valid;
  assign w_grant_ok = (w_grant != '0) && ((w_grant & (w_grant - P_ONE)) == '0);
  assign w_clear    = ((r_state == ST_WAIT_GRANT) && w_grant_ok) ? w_grant : '0;

  assign in_ready    = ~r_slot_valid;
  assign arb_request = (r_state == ST_ISSUE) ? '0 : r_slot_valid;

  assign out_valid = r_out_valid;
  assign out_op    = r_out_op;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;
  assign out_port  = r_out_port;

  // Binary index of the (one-hot) masked grant.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) w_grant_idx = PORT_W'(i);
    end
  end

  // Slot occupancy: set on accept, cleared when the slot is moved to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_valid <= '0;
    end else begin
      r_slot_valid <= (r_slot_valid & ~w_clear) | w_accept;
    end
  end

  // Slot payload capture; contents are only meaningful while the slot is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_accept[i]) begin
        r_slot_op[i]   <= in_op[i*OP_WIDTH +: OP_WIDTH];
        r_slot_addr[i] <= in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        r_slot_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Sequencer and registered output channel; out_* hold their last values when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_port  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_slot_valid) r_state <= ST_WAIT_GRANT;
        end
        ST_WAIT_GRANT: begin
          if (w_grant_ok) begin
            r_out_op    <= r_slot_op[w_grant_idx];
            r_out_addr  <= r_slot_addr[w_grant_idx];
            r_out_data  <= r_slot_data[w_grant_idx];
            r_out_port  <= w_grant_idx;
            r_out_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
